// File: rtl/mem_port_arbiter.sv
// Shares one single-ported SRAM (1-cycle read latency) among NumPorts requesters.
// Round-robin arbitration with an optional burst lock bounded by MaxLock, and
// read data returned to the port that issued the read one cycle after its grant.
module mem_port_arbiter #(
    parameter int unsigned NumPorts   = 2,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MaxLock    = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumPorts-1:0]              req_i,
    input  logic [NumPorts-1:0]              lock_i,
    input  logic [NumPorts-1:0]              we_i,
    input  logic [NumPorts*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NumPorts*DATA_WIDTH/8-1:0] be_i,
    input  logic [NumPorts*DATA_WIDTH-1:0]   wdata_i,
    output logic [NumPorts-1:0]              gnt_o,
    output logic [NumPorts-1:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic                             mem_req_o,
    output logic                             mem_we_o,
    output logic [ADDR_WIDTH-1:0]            mem_addr_o,
    output logic [DATA_WIDTH/8-1:0]          mem_be_o,
    output logic [DATA_WIDTH-1:0]            mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]            mem_rdata_i
);

    localparam int unsigned BeWidth = DATA_WIDTH / 8;
    localparam int unsigned IdxW    = $clog2(NumPorts);
    localparam int unsigned CntW    = (MaxLock == 0) ? 1 : $clog2(MaxLock + 1);

    localparam logic [IdxW-1:0] LastIdx    = IdxW'(NumPorts - 1);
    localparam logic [IdxW:0]   NumPortsW  = (IdxW + 1)'(NumPorts);
    localparam logic [CntW-1:0] CntOne     = CntW'(1);
    localparam logic [CntW-1:0] CntMax     = '1;
    localparam logic [CntW-1:0] MaxLockCnt = CntW'(MaxLock);

    logic [IdxW-1:0] rr_q, rr_d;
    logic            locked_q, locked_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
    logic            rpend_q, rpend_d;
    logic [IdxW-1:0] rsel_q, rsel_d;

    logic            gnt_any;
    logic [IdxW-1:0] gnt_idx;
    logic [IdxW:0]   scan_w;
    logic [IdxW-1:0] scan_idx;
    logic [CntW-1:0] cnt_next;

    // Pick the winner: the lock owner while it keeps requesting, otherwise the
    // first requester at or after the round-robin pointer. Nothing is granted in reset.
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a default
        // first, so no path leaves it holding its old value (which would infer a latch).
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_w   = '0;
        scan_idx = '0;
        gnt_o    = '0;
        if (rst_ni) begin
            if (locked_q && req_i[owner_q]) begin
                gnt_any = 1'b1;
                gnt_idx = owner_q;
            end else begin
                for (int i = 0; i < NumPorts; i++) begin
                    scan_w = {1'b0, rr_q} + (IdxW + 1)'(i);
                    if (scan_w >= NumPortsW) begin
                        scan_w = scan_w - NumPortsW;
                    end
                    scan_idx = scan_w[IdxW-1:0];
                    if (!gnt_any && req_i[scan_idx]) begin
                        gnt_any = 1'b1;
                        gnt_idx = scan_idx;
                    end
                end
            end
            if (gnt_any) begin
                gnt_o[gnt_idx] = 1'b1;
            end
        end
    end

    // Route the granted port's command to the SRAM; all fields are zero when idle.
    always_comb begin
        mem_req_o   = gnt_any;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        for (int k = 0; k < NumPorts; k++) begin
            mem_we_o    = mem_we_o    | (we_i[k] & gnt_o[k]);
            mem_addr_o  = mem_addr_o  | (addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{gnt_o[k]}});
            mem_be_o    = mem_be_o    | (be_i[k*BeWidth +: BeWidth] & {BeWidth{gnt_o[k]}});
            mem_wdata_o = mem_wdata_o | (wdata_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt_o[k]}});
        end
    end

    // Next pointer, lock and read-return state derived from this cycle's grant.
    always_comb begin
        rr_d       = rr_q;
        locked_d   = locked_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        cnt_next   = lock_cnt_q;
        rpend_d    = 1'b0;
        rsel_d     = rsel_q;

        if (gnt_any) begin
            rr_d    = (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
            rpend_d = !we_i[gnt_idx];
            rsel_d  = gnt_idx;

            if (lock_i[gnt_idx]) begin
                // Continuing the owner's burst counts up; any other grant starts a new burst.
                if (locked_q && (gnt_idx == owner_q)) begin
                    cnt_next = (lock_cnt_q == CntMax) ? lock_cnt_q : lock_cnt_q + 1'b1;
                end else begin
                    cnt_next = CntOne;
                end
                if ((MaxLock != 0) && (cnt_next >= MaxLockCnt)) begin
                    // Burst budget used up: the owner has to win arbitration again.
                    locked_d   = 1'b0;
                    lock_cnt_d = '0;
                end else begin
                    locked_d   = 1'b1;
                    owner_d    = gnt_idx;
                    lock_cnt_d = cnt_next;
                end
            end else begin
                locked_d   = 1'b0;
                lock_cnt_d = '0;
            end
        end else if (locked_q) begin
            // Owner stopped requesting and nobody else was waiting.
            locked_d   = 1'b0;
            lock_cnt_d = '0;
        end
    end

    // State registers; reset drops any pending read return and any held lock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the values from before the edge, independent of statement order.
        if (!rst_ni) begin
            rr_q       <= '0;
            locked_q   <= 1'b0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            rpend_q    <= 1'b0;
            rsel_q     <= '0;
        end else begin
            rr_q       <= rr_d;
            locked_q   <= locked_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            rpend_q    <= rpend_d;
            rsel_q     <= rsel_d;
        end
    end

    // Read data is shared; the valid strobe tells which port it belongs to.
    always_comb begin
        rvalid_o         = '0;
        rvalid_o[rsel_q] = rpend_q;
        rdata_o          = mem_rdata_i;
    end

endmodule
